pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/pc_fetch_if.sv | 30 +++
 rtl/ret_stack.sv | 62 ++++++
 rtl/pc_fetch.sv | 80 ++++++++
 tb/tb_pc_fetch.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, opcode map and fetch-path selectors.
package cpu_pkg;

  localparam int unsigned DefPcW      = 10;
  localparam int unsigned DefStkDepth = 4;

  // Control-unit opcode map; the fetch path only sees its decoded strobes.
  typedef enum logic [3:0] {
    OpAlu  = 4'h0,
    OpLdi  = 4'h1,
    OpJmp  = 4'h2,
    OpJz   = 4'h3,
    OpJnz  = 4'h4,
    OpCall = 4'h5,
    OpRet  = 4'h6
  } opcode_e;

  // Source of the next program counter value.
  typedef enum logic [1:0] {
    PcSelInc  = 2'd0,
    PcSelJump = 2'd1,
    PcSelRet  = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/pc_fetch_if.sv
// Control-unit <-> fetch-path bundle: branch strobes in, PC and flags out.
interface pc_fetch_if
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = DefPcW
) ();

  logic            s_inc;
  logic [PC_W-1:0] jump_addr;
  logic            push;
  logic            pop;
  logic            alu_z;
  logic            wez;
  logic [PC_W-1:0] pc;
  logic            z;
  logic            stk_full;
  logic            stk_empty;
  logic            stk_err;

  modport master (
    output s_inc, jump_addr, push, pop, alu_z, wez,
    input  pc, z, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  s_inc, jump_addr, push, pop, alu_z, wez,
    output pc, z, stk_full, stk_empty, stk_err
  );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO with occupancy counter and a per-cycle error pulse.
module ret_stack
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DefPcW,
  parameter int unsigned DEPTH = DefStkDepth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    rd_idx;
  logic             do_push, do_pop;

  // Extra counter bit keeps full (DEPTH) and empty (0) distinct.
  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign rd_idx = cnt_q[AW-1:0] - AW'(1);
  assign dout   = mem_q[rd_idx];

  // Qualify requests; simultaneous push and pop is a conflict that leaves the stack alone.
  always_comb begin
    do_push = push & ~pop & ~full;
    do_pop  = pop & ~push & ~empty;
    err     = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
    cnt_d   = cnt_q;
    if (do_push) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are left as-is over reset.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem_q[cnt_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Program counter, next-PC mux, zero flag and sticky stack-error flag.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W      = DefPcW,
  parameter int unsigned STK_DEPTH = DefStkDepth
) (
  input logic       clk,
  input logic       reset,
  pc_fetch_if.slave bus
);

  logic [PC_W-1:0] pc_q, pc_d, pc_inc, ret_addr;
  logic            z_q, z_d;
  logic            err_q, err_d;
  logic            stk_full, stk_empty, stk_err_pulse;
  pc_sel_e         pc_sel;

  assign pc_inc = pc_q + PC_W'(1);

  ret_stack #(
    .WIDTH(PC_W),
    .DEPTH(STK_DEPTH)
  ) u_ret_stack (
    .clk  (clk),
    .reset(reset),
    .push (bus.push),
    .pop  (bus.pop),
    .din  (pc_inc),
    .dout (ret_addr),
    .full (stk_full),
    .empty(stk_empty),
    .err  (stk_err_pulse)
  );

  // Next-PC source by priority: conflict, pop, push, jump, increment.
  always_comb begin
    pc_sel = PcSelInc;
    if (bus.push && bus.pop) begin
      pc_sel = PcSelInc;
    end else if (bus.pop) begin
      pc_sel = stk_empty ? PcSelInc : PcSelRet;
    end else if (bus.push) begin
      pc_sel = PcSelJump;
    end else if (!bus.s_inc) begin
      pc_sel = PcSelJump;
    end
  end

  // Next-state values for PC, Z and the sticky error.
  always_comb begin
    unique case (pc_sel)
      PcSelJump: pc_d = bus.jump_addr;
      PcSelRet:  pc_d = ret_addr;
      default:   pc_d = pc_inc;
    endcase
    z_d   = bus.wez ? bus.alu_z : z_q;
    err_d = err_q | stk_err_pulse;
  end

  // State registers; reset overrides any concurrent branch request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= '0;
      z_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      z_q   <= z_d;
      err_q <= err_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.z         = z_q;
  assign bus.stk_full  = stk_full;
  assign bus.stk_empty = stk_empty;
  assign bus.stk_err   = err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed and randomized checks of pc_fetch against a queue-based reference model.
module tb_pc_fetch;
  import cpu_pkg::*;

  localparam int unsigned PW = 10;
  localparam int unsigned SD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_fetch_if #(.PC_W(PW)) bus ();

  pc_fetch #(
    .PC_W     (PW),
    .STK_DEPTH(SD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: PC as a wrapping PW-bit value, stack as a queue.
  logic [PW-1:0] m_pc;
  logic [PW-1:0] m_inc;
  logic          m_z;
  logic          m_err;
  logic [PW-1:0] m_stk[$];
  bit            m_valid = 1'b0;

  always @(posedge clk) begin
    m_inc = m_pc + PW'(1);
    if (!reset) begin
      m_pc    = '0;
      m_z     = 1'b0;
      m_err   = 1'b0;
      m_stk.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (bus.wez) m_z = bus.alu_z;
      if (bus.push && bus.pop) begin
        m_err = 1'b1;
        m_pc  = m_inc;
      end else if (bus.pop) begin
        if (m_stk.size() == 0) begin
          m_err = 1'b1;
          m_pc  = m_inc;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (bus.push) begin
        if (m_stk.size() == int'(SD)) m_err = 1'b1;
        else m_stk.push_back(m_inc);
        m_pc = bus.jump_addr;
      end else if (!bus.s_inc) begin
        m_pc = bus.jump_addr;
      end else begin
        m_pc = m_inc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model pc", 32'(bus.pc), 32'(m_pc));
      check("model z", 32'(bus.z), 32'(m_z));
      check("model stk_err", 32'(bus.stk_err), 32'(m_err));
      check("model stk_full", 32'(bus.stk_full), 32'(m_stk.size() == int'(SD)));
      check("model stk_empty", 32'(bus.stk_empty), 32'(m_stk.size() == 0));
    end
  end

  task automatic step(input logic si, input logic [PW-1:0] ja, input logic pu, input logic po,
                      input logic az, input logic we, input logic rs);
    bus.s_inc     = si;
    bus.jump_addr = ja;
    bus.push      = pu;
    bus.pop       = po;
    bus.alu_z     = az;
    bus.wez       = we;
    reset         = rs;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic seq_step();               step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic jmp(input logic [PW-1:0] a); step(1'b0, a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic call(input logic [PW-1:0] a); step(1'b1, a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic ret();                    step(1'b0, 10'h3C3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); endtask
  task automatic do_reset();               step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  initial begin
    reset         = 1'b0;
    bus.s_inc     = 1'b1;
    bus.jump_addr = '0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.alu_z     = 1'b0;
    bus.wez       = 1'b0;

    // Reset then sequential run.
    do_reset();
    check("reset pc", 32'(bus.pc), 32'h0);
    check("reset z", 32'(bus.z), 32'h0);
    check("reset empty", 32'(bus.stk_empty), 32'h1);
    check("reset full", 32'(bus.stk_full), 32'h0);
    check("reset err", 32'(bus.stk_err), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      seq_step();
      check("seq pc", 32'(bus.pc), 32'(i));
    end
    check("seq z", 32'(bus.z), 32'h0);
    check("seq empty", 32'(bus.stk_empty), 32'h1);

    // Jump and zero flag.
    seq_step();
    seq_step();
    check("pc before jump", 32'(bus.pc), 32'h7);
    jmp(10'h2A);
    check("jump pc", 32'(bus.pc), 32'h2A);
    step(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("z set", 32'(bus.z), 32'h1);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("z hold", 32'(bus.z), 32'h1);

    // Nested call/return.
    jmp(10'h10);
    call(10'h80);
    check("call1 pc", 32'(bus.pc), 32'h80);
    call(10'h90);
    check("call2 pc", 32'(bus.pc), 32'h90);
    ret();
    check("ret1 pc", 32'(bus.pc), 32'h81);
    ret();
    check("ret2 pc", 32'(bus.pc), 32'h11);
    check("nest empty", 32'(bus.stk_empty), 32'h1);
    check("nest err", 32'(bus.stk_err), 32'h0);

    // Fill, overflow, drain in LIFO order.
    call(10'h100);
    call(10'h110);
    call(10'h120);
    call(10'h130);
    check("fill full", 32'(bus.stk_full), 32'h1);
    check("fill err", 32'(bus.stk_err), 32'h0);
    call(10'h140);
    check("overflow pc", 32'(bus.pc), 32'h140);
    check("overflow err", 32'(bus.stk_err), 32'h1);
    check("overflow full", 32'(bus.stk_full), 32'h1);
    ret();
    check("drain1", 32'(bus.pc), 32'h121);
    ret();
    check("drain2", 32'(bus.pc), 32'h111);
    ret();
    check("drain3", 32'(bus.pc), 32'h101);
    ret();
    check("drain4", 32'(bus.pc), 32'h12);
    check("drain empty", 32'(bus.stk_empty), 32'h1);

    // Underflow and push/pop conflict.
    do_reset();
    jmp(10'h05);
    ret();
    check("underflow pc", 32'(bus.pc), 32'h06);
    check("underflow err", 32'(bus.stk_err), 32'h1);
    step(1'b0, 10'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("conflict pc", 32'(bus.pc), 32'h07);
    check("conflict empty", 32'(bus.stk_empty), 32'h1);
    call(10'h20);
    step(1'b0, 10'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("conflict2 pc", 32'(bus.pc), 32'h21);
    check("conflict2 empty", 32'(bus.stk_empty), 32'h0);
    ret();
    check("conflict2 ret", 32'(bus.pc), 32'h08);

    // Wrap and reset overriding a push.
    jmp(10'h3FF);
    seq_step();
    check("wrap pc", 32'(bus.pc), 32'h0);
    call(10'h55);
    step(1'b1, 10'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset push pc", 32'(bus.pc), 32'h0);
    check("reset push empty", 32'(bus.stk_empty), 32'h1);
    check("reset push err", 32'(bus.stk_err), 32'h0);

    // Randomized traffic, checked every cycle by the model comparison.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), PW'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
